// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline datapath and pipe_ctrl.
// Defining CTRL_PERF_CNT_EN adds the stall/flush performance counter outputs.
interface pipe_ctrl_if;
    logic [4:0]  id_rs1_raddr_i;
    logic [4:0]  id_rs2_raddr_i;
    logic [1:0]  id_rs_used_i;
    logic        ex_valid_i;
    logic [4:0]  ex_rd_waddr_i;
    logic [2:0]  ex_wb_sel_i;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        hold_ex_mem_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;
    logic        mem_err_o;
    logic [1:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    // Pipeline side: reports hazards and memory status, obeys holds/flushes.
    modport master (
        output id_rs1_raddr_i, id_rs2_raddr_i, id_rs_used_i, ex_valid_i,
               ex_rd_waddr_i, ex_wb_sel_i, ex_jump_i, ex_jump_addr_i,
               mem_req_i, mem_ack_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
               flush_if_id_o, flush_id_ex_o, jump_o, jump_addr_o,
               mem_err_o, state_o
`ifdef CTRL_PERF_CNT_EN
        , input stall_cnt_o, flush_cnt_o
`endif
    );

    // Controller side.
    modport slave (
        input  id_rs1_raddr_i, id_rs2_raddr_i, id_rs_used_i, ex_valid_i,
               ex_rd_waddr_i, ex_wb_sel_i, ex_jump_i, ex_jump_addr_i,
               mem_req_i, mem_ack_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
               flush_if_id_o, flush_id_ex_o, jump_o, jump_addr_o,
               mem_err_o, state_o
`ifdef CTRL_PERF_CNT_EN
        , output stall_cnt_o, flush_cnt_o
`endif
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory stalls with timeout, EX jump redirect, load-use bubbles.
// Optional CTRL_PERF_CNT_EN adds stall-cycle and jump counters.
module pipe_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b10,
        ST_REDIRECT = 2'b11
    } state_e;

    state_e      state_r;
    state_e      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic        jump_pend_r;
    logic [31:0] jump_pend_addr_r;

    logic        load_use_s;
    logic        timeout_s;
    logic        latch_jump_s;
    logic        clr_pend_s;
    logic        hold_pc_s;
    logic        hold_if_id_s;
    logic        hold_id_ex_s;
    logic        hold_ex_mem_s;
    logic        flush_if_id_s;
    logic        flush_id_ex_s;
    logic        jump_s;
    logic [31:0] jump_addr_s;
    logic        mem_err_s;

    function automatic logic rs_hit(input logic [4:0] rs, input logic used, input logic [4:0] rd);
        return used && (rs == rd);
    endfunction

    assign load_use_s = ctrl.ex_valid_i && (ctrl.ex_wb_sel_i == 3'b011) &&
                        (ctrl.ex_rd_waddr_i != 5'd0) &&
                        (rs_hit(ctrl.id_rs1_raddr_i, ctrl.id_rs_used_i[0], ctrl.ex_rd_waddr_i) ||
                         rs_hit(ctrl.id_rs2_raddr_i, ctrl.id_rs_used_i[1], ctrl.ex_rd_waddr_i));

    // Counter reads k-1 in the k-th wait cycle, so the timeout fires on cycle MEM_TIMEOUT.
    assign timeout_s = (wait_cnt_r == (MEM_TIMEOUT - 8'd1));

    // Next-state and output decode; priority is memory stall, then jump, then load-use.
    always_comb begin
        state_nxt_s   = state_r;
        hold_pc_s     = 1'b0;
        hold_if_id_s  = 1'b0;
        hold_id_ex_s  = 1'b0;
        hold_ex_mem_s = 1'b0;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        jump_s        = 1'b0;
        jump_addr_s   = 32'd0;
        mem_err_s     = 1'b0;
        latch_jump_s  = 1'b0;
        clr_pend_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ctrl.mem_req_i && !ctrl.mem_ack_i) begin
                    hold_pc_s     = 1'b1;
                    hold_if_id_s  = 1'b1;
                    hold_id_ex_s  = 1'b1;
                    hold_ex_mem_s = 1'b1;
                    latch_jump_s  = ctrl.ex_jump_i;
                    state_nxt_s   = ST_MEM_WAIT;
                end else if (ctrl.ex_jump_i) begin
                    jump_s        = 1'b1;
                    jump_addr_s   = ctrl.ex_jump_addr_i;
                    flush_if_id_s = 1'b1;
                    flush_id_ex_s = 1'b1;
                    state_nxt_s   = ST_REDIRECT;
                end else if (load_use_s) begin
                    hold_pc_s     = 1'b1;
                    hold_if_id_s  = 1'b1;
                    flush_id_ex_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (ctrl.mem_ack_i) begin
                    clr_pend_s = 1'b1;
                    if (jump_pend_r) begin
                        jump_s        = 1'b1;
                        jump_addr_s   = jump_pend_addr_r;
                        flush_if_id_s = 1'b1;
                        flush_id_ex_s = 1'b1;
                        state_nxt_s   = ST_REDIRECT;
                    end else if (ctrl.ex_jump_i) begin
                        jump_s        = 1'b1;
                        jump_addr_s   = ctrl.ex_jump_addr_i;
                        flush_if_id_s = 1'b1;
                        flush_id_ex_s = 1'b1;
                        state_nxt_s   = ST_REDIRECT;
                    end else begin
                        state_nxt_s   = ST_RUN;
                    end
                end else if (timeout_s) begin
                    mem_err_s     = 1'b1;
                    flush_id_ex_s = 1'b1;
                    clr_pend_s    = 1'b1;
                    state_nxt_s   = ST_RUN;
                end else begin
                    hold_pc_s     = 1'b1;
                    hold_if_id_s  = 1'b1;
                    hold_id_ex_s  = 1'b1;
                    hold_ex_mem_s = 1'b1;
                    latch_jump_s  = ctrl.ex_jump_i;
                    state_nxt_s   = ST_MEM_WAIT;
                end
            end
            ST_REDIRECT: begin
                // The jump itself occupies MEM here, so no stall or new jump can arise.
                flush_id_ex_s = 1'b1;
                state_nxt_s   = ST_RUN;
            end
            default: begin
                state_nxt_s   = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter: held at zero outside MEM_WAIT so every entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r == ST_MEM_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Pending jump captured during a stall; the first target seen is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_pend_r      <= 1'b0;
            jump_pend_addr_r <= 32'd0;
        end else if (clr_pend_s) begin
            jump_pend_r      <= 1'b0;
            jump_pend_addr_r <= 32'd0;
        end else if (latch_jump_s && !jump_pend_r) begin
            jump_pend_r      <= 1'b1;
            jump_pend_addr_r <= ctrl.ex_jump_addr_i;
        end else begin
            jump_pend_r      <= jump_pend_r;
            jump_pend_addr_r <= jump_pend_addr_r;
        end
    end

    assign ctrl.hold_pc_o     = hold_pc_s;
    assign ctrl.hold_if_id_o  = hold_if_id_s;
    assign ctrl.hold_id_ex_o  = hold_id_ex_s;
    assign ctrl.hold_ex_mem_o = hold_ex_mem_s;
    assign ctrl.flush_if_id_o = flush_if_id_s;
    assign ctrl.flush_id_ex_o = flush_id_ex_s;
    assign ctrl.jump_o        = jump_s;
    assign ctrl.jump_addr_o   = jump_addr_s;
    assign ctrl.mem_err_o     = mem_err_s;
    assign ctrl.state_o       = state_r;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Performance counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, hold_pc_s};
            flush_cnt_r <= flush_cnt_r + {31'd0, jump_s};
        end
    end

    assign ctrl.stall_cnt_o = stall_cnt_r;
    assign ctrl.flush_cnt_o = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  used;
        logic        ex_valid;
        logic [4:0]  rd;
        logic [2:0]  wb;
        logic        jump;
        logic [31:0] jaddr;
        logic        req;
        logic        ack;
    } stim_t;

    typedef struct packed {
        logic        chk;
        logic [1:0]  state;
        logic [3:0]  holds;   // {pc, if_id, id_ex, ex_mem}
        logic [1:0]  flush;   // {if_id, id_ex}
        logic        jump;
        logic [31:0] jaddr;
        logic        err;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    logic clk;
    logic rst;
    pipe_ctrl_if bus();

    pipe_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Behavioural model state
    bit          m_waiting    = 1'b0;
    bit          m_redirect   = 1'b0;
    int          m_wait_cycles = 0;
    logic [31:0] m_pend[$];
    logic [31:0] m_stall_cnt  = 32'd0;
    logic [31:0] m_flush_cnt  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_use(input stim_t s);
        int reads[$];
        if (!(s.ex_valid && s.wb == 3'b011) || s.rd == 5'd0) return 1'b0;
        if (s.used[0]) reads.push_back(int'(s.rs1));
        if (s.used[1]) reads.push_back(int'(s.rs2));
        foreach (reads[k]) if (reads[k] == int'(s.rd)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit          take_jump;
        logic [31:0] tgt;
        e = '0;
        e.chk = ~s.rst;
        e.stall_cnt = m_stall_cnt;
        e.flush_cnt = m_flush_cnt;
        take_jump = 1'b0;
        tgt = 32'd0;
        if (m_redirect) begin
            e.state = 2'b11;
            e.flush = 2'b01;
            m_redirect = 1'b0;
        end else if (m_waiting) begin
            e.state = 2'b10;
            if (s.ack) begin
                m_waiting = 1'b0;
                if (m_pend.size() > 0) begin
                    take_jump = 1'b1;
                    tgt = m_pend.pop_front();
                end else if (s.jump) begin
                    take_jump = 1'b1;
                    tgt = s.jaddr;
                end
            end else if (m_wait_cycles + 1 == TIMEOUT) begin
                e.err = 1'b1;
                e.flush = 2'b01;
                m_waiting = 1'b0;
                m_pend.delete();
            end else begin
                e.holds = 4'b1111;
                m_wait_cycles++;
                if (s.jump && m_pend.size() == 0) m_pend.push_back(s.jaddr);
            end
        end else begin
            e.state = 2'b00;
            if (s.req && !s.ack) begin
                e.holds = 4'b1111;
                m_waiting = 1'b1;
                m_wait_cycles = 0;
                if (s.jump) m_pend.push_back(s.jaddr);
            end else if (s.jump) begin
                take_jump = 1'b1;
                tgt = s.jaddr;
            end else if (load_use(s)) begin
                e.holds = 4'b1100;
                e.flush = 2'b01;
            end
        end
        if (take_jump) begin
            e.jump = 1'b1;
            e.jaddr = tgt;
            e.flush = 2'b11;
            m_redirect = 1'b1;
        end
        if (e.holds[3]) m_stall_cnt = m_stall_cnt + 32'd1;
        if (e.jump) m_flush_cnt = m_flush_cnt + 32'd1;
        if (s.rst) begin
            m_waiting = 1'b0;
            m_redirect = 1'b0;
            m_wait_cycles = 0;
            m_pend.delete();
            m_stall_cnt = 32'd0;
            m_flush_cnt = 32'd0;
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst                = s.rst;
        bus.id_rs1_raddr_i = s.rs1;
        bus.id_rs2_raddr_i = s.rs2;
        bus.id_rs_used_i   = s.used;
        bus.ex_valid_i     = s.ex_valid;
        bus.ex_rd_waddr_i  = s.rd;
        bus.ex_wb_sel_i    = s.wb;
        bus.ex_jump_i      = s.jump;
        bus.ex_jump_addr_i = s.jaddr;
        bus.mem_req_i      = s.req;
        bus.mem_ack_i      = s.ack;
        model_step(s, e);
        sb.push_back(e);
    endtask

    function automatic stim_t mk(input logic req, input logic ack, input logic jump,
                                 input logic [31:0] jaddr);
        stim_t s;
        s = '0;
        s.req = req;
        s.ack = ack;
        s.jump = jump;
        s.jaddr = jaddr;
        return s;
    endfunction

    function automatic stim_t mk_load(input logic [4:0] rd, input logic [4:0] rs2);
        stim_t s;
        s = '0;
        s.ex_valid = 1'b1;
        s.wb = 3'b011;
        s.rd = rd;
        s.rs2 = rs2;
        s.used = 2'b10;
        return s;
    endfunction

    function automatic stim_t mk_rand();
        stim_t s;
        s.rst      = ($urandom_range(0, 199) == 0);
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.used     = 2'($urandom_range(0, 3));
        s.ex_valid = 1'($urandom_range(0, 1));
        s.rd       = 5'($urandom_range(0, 3));
        s.wb       = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
        s.jump     = ($urandom_range(0, 5) == 0);
        s.jaddr    = $urandom;
        s.req      = ($urandom_range(0, 3) == 0);
        s.ack      = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    // Monitor: compares each presented cycle of outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("state_o", 32'(bus.state_o), 32'(e.state));
                    check("holds", 32'({bus.hold_pc_o, bus.hold_if_id_o, bus.hold_id_ex_o,
                                        bus.hold_ex_mem_o}), 32'(e.holds));
                    check("flushes", 32'({bus.flush_if_id_o, bus.flush_id_ex_o}), 32'(e.flush));
                    check("jump_o", 32'(bus.jump_o), 32'(e.jump));
                    check("jump_addr_o", bus.jump_addr_o, e.jaddr);
                    check("mem_err_o", 32'(bus.mem_err_o), 32'(e.err));
`ifdef CTRL_PERF_CNT_EN
                    check("stall_cnt_o", bus.stall_cnt_o, e.stall_cnt);
                    check("flush_cnt_o", bus.flush_cnt_o, e.flush_cnt);
`endif
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        bus.id_rs1_raddr_i = 5'd0;
        bus.id_rs2_raddr_i = 5'd0;
        bus.id_rs_used_i   = 2'd0;
        bus.ex_valid_i     = 1'b0;
        bus.ex_rd_waddr_i  = 5'd0;
        bus.ex_wb_sel_i    = 3'd0;
        bus.ex_jump_i      = 1'b0;
        bus.ex_jump_addr_i = 32'd0;
        bus.mem_req_i      = 1'b0;
        bus.mem_ack_i      = 1'b0;

        s = '0;
        s.rst = 1'b1;
        drive(s);
        drive(mk(1'b0, 1'b0, 1'b0, 32'd0));           // post-reset: all zero

        drive(mk_load(5'd5, 5'd5));                    // load-use on rs2
        drive(mk_load(5'd0, 5'd0));                    // rd = x0: no hazard
        drive(mk(1'b0, 1'b0, 1'b1, 32'h100));          // jump in RUN
        drive(mk(1'b0, 1'b0, 1'b0, 32'd0));            // REDIRECT
        drive(mk(1'b0, 1'b0, 1'b0, 32'd0));            // back in RUN

        drive(mk(1'b1, 1'b0, 1'b0, 32'd0));            // stall entry
        repeat (3) drive(mk(1'b1, 1'b0, 1'b0, 32'd0));
        drive(mk(1'b1, 1'b1, 1'b0, 32'd0));            // ack releases
        drive(mk(1'b1, 1'b1, 1'b0, 32'd0));            // req+ack same cycle: no stall

        drive(mk(1'b1, 1'b0, 1'b0, 32'd0));
        drive(mk(1'b1, 1'b0, 1'b1, 32'h40));           // jump latched during wait
        drive(mk(1'b1, 1'b0, 1'b1, 32'h99));           // later jump must not replace it
        drive(mk(1'b1, 1'b1, 1'b1, 32'h80));           // ack: latched 0x40 wins
        drive(mk(1'b0, 1'b0, 1'b0, 32'd0));            // REDIRECT

        drive(mk(1'b1, 1'b0, 1'b1, 32'h44));           // stall + jump, then timeout
        repeat (5) drive(mk(1'b1, 1'b0, 1'b0, 32'd0));
        drive(mk(1'b0, 1'b1, 1'b0, 32'd0));            // no stale jump after timeout

        drive(mk(1'b1, 1'b0, 1'b1, 32'h20));           // reset mid-wait drops pending jump
        drive(mk(1'b1, 1'b0, 1'b0, 32'd0));
        s = mk(1'b1, 1'b0, 1'b0, 32'd0);
        s.rst = 1'b1;
        drive(s);
        drive(mk(1'b0, 1'b0, 1'b0, 32'd0));
        drive(mk(1'b0, 1'b1, 1'b0, 32'd0));

        for (int i = 0; i < 3000; i++) begin
            drive(mk_rand());
        end
        repeat (3) drive(mk(1'b0, 1'b0, 1'b0, 32'd0));

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
